// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial A+B+Cin using one full-adder cell and a registered carry, LSB first
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0] cnt;
    logic carry;
    logic s;
    logic co;
    logic last;
    always_comb begin
        s    = a_sh[0] ^ b_sh[0] ^ carry;
        co   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
        last = cnt == CW'(WIDTH - 1);
        busy = state == ADD;
        done = state == DONE;
    end
    // start during ADD is deliberately ignored; only IDLE and DONE accept a new operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (start && state != ADD) begin
            state <= ADD;
            a_sh  <= A;
            b_sh  <= B;
            cnt   <= '0;
            carry <= Cin;
            Sum   <= '0;
            Cout  <= 1'b0;
        end else if (state == ADD) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            carry <= co;
            Sum   <= {s, Sum[WIDTH-1:1]};
            cnt   <= last ? cnt : cnt + CW'(1);
            Cout  <= last ? co : Cout;
            state <= last ? DONE : ADD;
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: directed and random checks of serial_full_adder against arithmetic A+B+Cin
module tb_serial_full_adder;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic Cin = 1'b0;
    logic [W-1:0] Sum;
    logic Cout;
    logic busy;
    logic done;
    int vectors = 0;
    int miscompares = 0;

    serial_full_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
        .Sum(Sum), .Cout(Cout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one add; poke>=0 pulses an ignored start with junk operands n cycles into ADD.
    // b2b leaves the DUT sitting in DONE so the caller can restart on the DONE edge.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int poke, input bit b2b);
        logic [W:0] exp;
        int n;
        int busy_cnt;
        exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        start = 1'b1;
        A = a;
        B = b;
        Cin = c;
        tick();
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Cin = 1'($urandom);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_done", 64'(done), 64'd0);
        n = 0;
        busy_cnt = 0;
        while (!done && n < W + 4) begin
            if (busy) busy_cnt++;
            start = (n == poke);
            if (n == poke) A = W'(8'hAA);
            tick();
            start = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(W));
        check("busy_cycles", 64'(busy_cnt), 64'(W));
        check("sum", 64'(Sum), 64'(exp[W-1:0]));
        check("cout", 64'(Cout), 64'(exp[W]));
        if (!b2b) begin
            tick();
            check("done_pulse", 64'(done), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("sum_hold", 64'(Sum), 64'(exp[W-1:0]));
            check("cout_hold", 64'(Cout), 64'(exp[W]));
        end
    endtask

    initial begin
        repeat (3) tick();
        check("rst_sum", 64'(Sum), 64'd0);
        check("rst_cout", 64'(Cout), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        tick();

        do_add(8'h5A, 8'h3C, 1'b0, -1, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0, -1, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1, -1, 1'b0);
        do_add(8'h00, 8'h00, 1'b1, -1, 1'b0);
        do_add(8'h12, 8'h34, 1'b0, 2, 1'b0);

        start = 1'b1;
        A = 8'hC3;
        B = 8'h7E;
        Cin = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_sum", 64'(Sum), 64'd0);
        check("midrst_cout", 64'(Cout), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        tick();
        check("midrst_idle", 64'(busy), 64'd0);
        do_add(8'h01, 8'h01, 1'b0, -1, 1'b0);

        do_add(8'h0F, 8'hF0, 1'b1, -1, 1'b1);
        do_add(8'h80, 8'h80, 1'b0, -1, 1'b0);

        for (int i = 0; i < 1000; i++)
            do_add(W'($urandom), W'($urandom), 1'($urandom), -1, 1'($urandom));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/serial_full_adder.md
# serial_full_adder

Bit-serial ripple adder: adds two WIDTH-bit operands plus carry-in by passing one bit pair per clock, LSB first, through a single full-adder cell and a registered carry. It is the additive counterpart of the combinational full subtractor in the arithmetic library. It trades WIDTH cycles of latency for one adder cell and sits behind a start/done handshake for use by control FSMs.

## Interface
Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32)

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request pulse; accepted only in IDLE or DONE
- A  input  WIDTH  operand A, sampled on the accepting edge only
- B  input  WIDTH  operand B, sampled on the accepting edge only
- Cin  input  1  carry-in, sampled on the accepting edge only
- Sum  output  WIDTH  result (A + B + Cin) mod 2^WIDTH, registered
- Cout  output  1  carry out of bit WIDTH-1, registered
- busy  output  1  high while in ADD
- done  output  1  one-cycle pulse: Sum/Cout valid

## Operation
- States: IDLE, ADD, DONE.
  - IDLE -> ADD on start=1.
  - ADD -> DONE when bit counter reaches WIDTH-1 after processing.
  - DONE -> ADD on start=1, else DONE -> IDLE.
- Accepting edge: loads shift registers with A and B, loads carry register with Cin, clears bit counter to 0, clears Sum and Cout.
- Each ADD edge:
  - Bit cell: s = a0 ^ b0 ^ c; co = (a0 & b0) | (c & (a0 ^ b0)), where a0/b0 are the shift-register LSBs.
  - Shift s into the MSB of the Sum shift register; shift the A and B registers right by one.
  - Carry register <= co; counter increments.
- On the final ADD edge (counter = WIDTH-1), Cout <= co and Sum holds the complete result.
- Sum and Cout hold their value through DONE and IDLE until the next accepting edge.
- start while in ADD is ignored: no restart, no queuing, operands are not sampled.
- Reset (rst_n=0 at an edge) overrides everything, including mid-operation: state <= IDLE, counter <= 0, carry <= 0, Sum <= 0, Cout <= 0, busy <= 0, done <= 0. The partial result is discarded.
- Counter width is ceil(log2(WIDTH)) bits. It never wraps while in ADD.

## Timing
- Reset values: Sum=0, Cout=0, busy=0, done=0, state IDLE.
- busy and done are decoded from the registered state: busy = (state==ADD), done = (state==DONE).
- Let start be accepted at edge k:
  - busy=1 for cycles following edges k..k+WIDTH-1.
  - done=1 for exactly the cycle following edge k+WIDTH.
  - Latency from accepting edge to done is WIDTH cycles.
- Back-to-back: start=1 while done=1 is accepted at that edge. busy rises next cycle and done falls. Throughput is one add per WIDTH+1 cycles.
- Inputs A, B and Cin may change freely after the accepting edge.

## Test plan
- Reset, then WIDTH=8, start with A=0x5A, B=0x3C, Cin=0 -> done 8 cycles after the accepting edge; Sum=0x96, Cout=0; busy high exactly 8 cycles.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1. Then A=0x00, B=0x00, Cin=1 -> Sum=0x01, Cout=0.
- Start A=0x12, B=0x34; pulse start with A=0xAA at cycle 3 of ADD -> ignored; result Sum=0x46 and done timing unchanged.
- rst_n=0 for one edge at cycle 4 of ADD -> next cycle Sum=0, Cout=0, busy=0, done=0, state IDLE; a fresh start of 0x01+0x01 -> Sum=0x02.
- start held high through DONE with A=0x80, B=0x80 -> accepted at the DONE edge; done pulses exactly one cycle; next result Sum=0x00, Cout=1 after 8 more cycles.
- Randomized sweep of 1000 operand/Cin triples, compared against (A+B+Cin) -> all Sum/Cout match; done always single-cycle.
